uart_tx_packetizer: RTL and testbench

- Upstream feeder for the UART transmitter, in the tx_clk domain.
- Accepts a byte stream with an end-of-message marker and buffers it in a FIFO.
- Hands bytes one at a time to the UART TX using its transmit/done handshake.
- Appends an XOR checksum byte after each message so the receiving side can detect errors.

---
 rtl/uart_tx_packetizer_if.sv | 24 ++
 rtl/uart_tx_packetizer.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx_packetizer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_packetizer_if.sv
// Stream-in / UART-out handshake bundle for uart_tx_packetizer.
// master: producer plus UART TX side (drives data in, returns tx_done).
// slave : the packetizer (accepts bytes, drives transmit/tx_data).
interface uart_tx_packetizer_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  transmit;
  logic                  tx_done;

  modport master (
    output s_data, s_last, s_valid, tx_done,
    input  s_ready, tx_data, transmit
  );

  modport slave (
    input  s_data, s_last, s_valid, tx_done,
    output s_ready, tx_data, transmit
  );
endinterface

// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: buffers an incoming byte stream in a FIFO, hands bytes one
// at a time to the UART TX over its transmit/tx_done handshake, and appends an
// XOR checksum byte after the byte flagged as last.
// Build option: define UART_PKT_SOF_EN to send SOF_BYTE ahead of every message.
module uart_tx_packetizer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = 8'h7E
) (
  input  logic                             tx_clk,
  input  logic                             reset,
  uart_tx_packetizer_if.slave              bus,
  output logic                             busy,
  output logic                             pkt_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_WIDTH + 1;
  localparam logic [AW-1:0] PTR_STEP = AW'(1);
  localparam logic [CW-1:0] CNT_STEP = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  // Running message checksum: one XOR fold per payload byte.
  function automatic logic [DATA_WIDTH-1:0] chk_fold(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] data
  );
    chk_fold = acc ^ data;
  endfunction

`ifdef UART_PKT_SOF_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT     = 3'd2,
    ST_CHK      = 3'd3,
    ST_CHK_WAIT = 3'd4,
    ST_SOF      = 3'd5,
    ST_SOF_WAIT = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT     = 3'd2,
    ST_CHK      = 3'd3,
    ST_CHK_WAIT = 3'd4
  } state_t;
  // Keeps the start-of-frame parameter referenced when no SOF byte is sent.
  logic sof_unused_s;
  assign sof_unused_s = ^SOF_BYTE;
`endif

  // FIFO storage, entry = {last, data}
  logic [EW-1:0]         mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [EW-1:0]         head_s;

  // Sequencer state and registered outputs
  state_t                state_r;
  state_t                state_next_s;
  logic [DATA_WIDTH-1:0] tx_data_r;
  logic [DATA_WIDTH-1:0] tx_data_s;
  logic                  transmit_r;
  logic                  transmit_s;
  logic                  pkt_done_r;
  logic                  pkt_done_s;
  logic [DATA_WIDTH-1:0] chk_r;
  logic [DATA_WIDTH-1:0] chk_s;
  logic                  last_r;
  logic                  last_s;

  assign full_s       = (count_r == CNT_FULL);
  assign empty_s      = (count_r == {CW{1'b0}});
  assign push_s       = bus.s_valid & ~full_s;
  assign head_s       = mem_r[rd_ptr_r];

  assign bus.s_ready  = ~full_s;
  assign bus.tx_data  = tx_data_r;
  assign bus.transmit = transmit_r;
  assign busy         = (state_r != ST_IDLE);
  assign pkt_done     = pkt_done_r;
  assign fifo_count   = count_r;

  // FIFO data array; contents need no reset since pointers define validity.
  always_ff @(posedge tx_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.s_last, bus.s_data};
    end
  end

  // FIFO pointers and occupancy; a push and pop in the same cycle cancel out.
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_STEP;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_STEP;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_STEP;
        2'b01:   count_r <= count_r - CNT_STEP;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; tx_done is only meaningful in the waiting states.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
`ifdef UART_PKT_SOF_EN
          state_next_s = ST_SOF;
`else
          state_next_s = ST_LOAD;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!empty_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (bus.tx_done) begin
          state_next_s = last_r ? ST_CHK : ST_LOAD;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CHK: state_next_s = ST_CHK_WAIT;
      ST_CHK_WAIT: begin
        if (bus.tx_done) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CHK_WAIT;
        end
      end
`ifdef UART_PKT_SOF_EN
      ST_SOF: state_next_s = ST_SOF_WAIT;
      ST_SOF_WAIT: begin
        if (bus.tx_done) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_SOF_WAIT;
        end
      end
`endif
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered UART-side outputs and FIFO pop.
  always_comb begin
    transmit_s = 1'b0;
    tx_data_s  = tx_data_r;
    pop_s      = 1'b0;
    chk_s      = chk_r;
    last_s     = last_r;
    pkt_done_s = 1'b0;
    case (state_r)
      ST_IDLE: chk_s = {DATA_WIDTH{1'b0}};
      ST_LOAD: begin
        if (!empty_s) begin
          transmit_s = 1'b1;
          tx_data_s  = head_s[DATA_WIDTH-1:0];
          pop_s      = 1'b1;
          chk_s      = chk_fold(chk_r, head_s[DATA_WIDTH-1:0]);
          last_s     = head_s[DATA_WIDTH];
        end else begin
          transmit_s = 1'b0;
        end
      end
      ST_CHK: begin
        transmit_s = 1'b1;
        tx_data_s  = chk_r;
      end
      ST_CHK_WAIT: begin
        if (bus.tx_done) begin
          pkt_done_s = 1'b1;
        end else begin
          pkt_done_s = 1'b0;
        end
      end
`ifdef UART_PKT_SOF_EN
      ST_SOF: begin
        transmit_s = 1'b1;
        tx_data_s  = SOF_BYTE;
      end
`endif
      default: transmit_s = 1'b0;
    endcase
  end

  // Output and checksum registers; transmit/pkt_done are single-cycle pulses.
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      tx_data_r  <= {DATA_WIDTH{1'b0}};
      transmit_r <= 1'b0;
      pkt_done_r <= 1'b0;
      chk_r      <= {DATA_WIDTH{1'b0}};
      last_r     <= 1'b0;
    end else begin
      tx_data_r  <= tx_data_s;
      transmit_r <= transmit_s;
      pkt_done_r <= pkt_done_s;
      chk_r      <= chk_s;
      last_r     <= last_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Self-checking bench for uart_tx_packetizer: table of messages with
// hand-computed checksums, plus sequences for latency, full FIFO, underrun
// and mid-operation reset. Honours UART_PKT_SOF_EN when defined.
module tb_uart_tx_packetizer;

  typedef struct packed {
    logic [3:0]      n;      // payload length
    logic [7:0][7:0] b;      // b[0] is the first byte sent
    logic [7:0]      chk;    // expected checksum byte
    logic [7:0]      delay;  // cycles from transmit to tx_done
  } vec_t;

`ifdef UART_PKT_SOF_EN
  localparam int FULL_ACC = 16;
  localparam int PRE_RST_COUNT = 5;
`else
  localparam int FULL_ACC = 17;
  localparam int PRE_RST_COUNT = 4;
`endif

  logic       tx_clk;
  logic       reset;
  logic       busy;
  logic       pkt_done;
  logic [4:0] fifo_count;

  uart_tx_packetizer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_packetizer #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(16),
    .SOF_BYTE  (8'h7E)
  ) dut (
    .tx_clk    (tx_clk),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .fifo_count(fifo_count)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] tx_log [$];
  logic [7:0] exp_q  [$];
  int         pkt_cnt;
  int         busy_low;
  int         consec;
  vec_t       vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic exp_begin();
    exp_q.delete();
`ifdef UART_PKT_SOF_EN
    exp_q.push_back(8'h7E);
`endif
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    @(negedge tx_clk);
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && w < 500) begin
      @(negedge tx_clk);
      w++;
    end
    check("push_ready_wait", 32'(w < 500), 32'd1);
    @(posedge tx_clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // UART TX model: logs each transmit, answers with tx_done after 'delay'
  // cycles, stops on pkt_done. cd_init>0 answers an already pending byte.
  task automatic serve(input int delay, input int cd_init, input int budget);
    int   cd;
    int   last_done_c;
    int   pkt_c;
    logic prev_tx;
    bit   seen;
    bit   done;
    cd = cd_init; prev_tx = 1'b0; seen = (cd_init > 0); done = 1'b0;
    last_done_c = -100; pkt_c = 0;
    pkt_cnt = 0; busy_low = 0; consec = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge tx_clk);
      bus.tx_done = 1'b0;
      if (bus.transmit && prev_tx) consec++;
      prev_tx = bus.transmit;
      if (pkt_done) begin
        pkt_cnt++;
        done  = 1'b1;
        pkt_c = c;
      end else if (seen && !busy) begin
        busy_low++;
      end
      if (bus.transmit) begin
        tx_log.push_back(bus.tx_data);
        seen = 1'b1;
        cd   = delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.tx_done = 1'b1;
          last_done_c = c;
        end
      end
    end
    check("pkt_done_seen", 32'(done), 32'd1);
    check("pkt_done_latency", 32'(pkt_c - last_done_c), 32'd1);
  endtask

  task automatic finish_checks(input string nm);
    check($sformatf("%s_len", nm), 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("%s_byte%0d", nm, i), 32'(tx_log[i]), 32'(exp_q[i]));
    check($sformatf("%s_pkt_cnt", nm), 32'(pkt_cnt), 32'd1);
    check($sformatf("%s_busy_gap", nm), 32'(busy_low), 32'd0);
    check($sformatf("%s_tx_back2back", nm), 32'(consec), 32'd0);
    @(negedge tx_clk);
    check($sformatf("%s_pkt_pulse", nm), 32'(pkt_done), 32'd0);
    check($sformatf("%s_idle_busy", nm), 32'(busy), 32'd0);
    check($sformatf("%s_idle_count", nm), 32'(fifo_count), 32'd0);
  endtask

  task automatic push_msg(input vec_t v);
    for (int i = 0; i < int'(v.n); i++)
      push_byte(v.b[i], (i == int'(v.n) - 1));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    tx_log.delete();
    exp_begin();
    for (int i = 0; i < int'(v.n); i++) exp_q.push_back(v.b[i]);
    exp_q.push_back(v.chk);
    fork
      push_msg(v);
      serve(int'(v.delay), 0, 3000);
    join
    finish_checks(nm);
  endtask

  initial begin
    int         acc;
    int         idx;
    logic       prev_acc;
    int         tx_seen;
    logic [7:0] xchk;

    // Message table: bytes listed last-to-first inside each packed b.
    vecs[0] = '{n: 4'd3, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h52, 8'h4E, 8'h45}, chk: 8'h59, delay: 8'd20};
    vecs[1] = '{n: 4'd7, b: {8'h00, 8'h45, 8'h55, 8'h51, 8'h49, 8'h52, 8'h4E, 8'h45}, chk: 8'h51, delay: 8'd3};
    vecs[2] = '{n: 4'd1, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, chk: 8'hA5, delay: 8'd2};
    vecs[3] = '{n: 4'd4, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, chk: 8'h08, delay: 8'd1};
    vecs[4] = '{n: 4'd2, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF}, chk: 8'h00, delay: 8'd4};
    vecs[5] = '{n: 4'd2, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h5A}, chk: 8'h55, delay: 8'd2};

    reset = 1'b1;
    bus.s_data = 8'h00; bus.s_last = 1'b0; bus.s_valid = 1'b0; bus.tx_done = 1'b0;
    repeat (3) @(negedge tx_clk);
    reset = 1'b0;
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_transmit", 32'(bus.transmit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);

    // Table-driven messages
    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Latency: byte pushed into an empty idle FIFO reaches transmit 2 cycles later
    tx_log.delete();
    push_byte(8'hC3, 1'b1);
    @(negedge tx_clk);
    check("lat_n0_transmit", 32'(bus.transmit), 32'd0);
    check("lat_n0_count", 32'(fifo_count), 32'd1);
    @(negedge tx_clk);
    check("lat_n1_transmit", 32'(bus.transmit), 32'd0);
    check("lat_n1_busy", 32'(busy), 32'd1);
    @(negedge tx_clk);
    check("lat_n2_transmit", 32'(bus.transmit), 32'd1);
    tx_log.push_back(bus.tx_data);
    repeat (3) @(negedge tx_clk);
    bus.tx_done = 1'b1;
    serve(3, 0, 3000);
    exp_begin();
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC3);
    finish_checks("lat");

    // Full FIFO: tx_done held low while the producer pushes every cycle
    tx_log.delete();
    acc = 0; idx = 0; prev_acc = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge tx_clk);
      if (bus.transmit) tx_log.push_back(bus.tx_data);
      if (prev_acc) idx++;
      bus.s_data  = 8'h10 + 8'(idx);
      bus.s_last  = 1'b0;
      bus.s_valid = 1'b1;
      prev_acc = bus.s_ready;
      if (bus.s_ready) acc++;
    end
    bus.s_valid = 1'b0;
    check("full_accepted", 32'(acc), 32'(FULL_ACC));
    check("full_s_ready", 32'(bus.s_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_tx_once", 32'(tx_log.size()), 32'd1);
    fork
      serve(4, 2, 3000);
      push_byte(8'h10 + 8'(FULL_ACC), 1'b1);
    join
    exp_begin();
    xchk = 8'h00;
    for (int k = 0; k <= FULL_ACC; k++) begin
      exp_q.push_back(8'h10 + 8'(k));
      xchk = xchk ^ (8'h10 + 8'(k));
    end
    exp_q.push_back(xchk);
    finish_checks("full");

    // Underrun: two bytes, a long gap, then the rest of the message
    tx_log.delete();
    exp_begin();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_q.push_back(8'h44);
    fork
      begin
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        repeat (47) @(negedge tx_clk);
        check("under_stall_transmit", 32'(bus.transmit), 32'd0);
        check("under_stall_busy", 32'(busy), 32'd1);
        check("under_stall_count", 32'(fifo_count), 32'd0);
        push_byte(8'h33, 1'b0);
        push_byte(8'h44, 1'b1);
      end
      serve(5, 0, 3000);
    join
    finish_checks("under");

    // Reset while waiting on the UART with bytes still queued
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i), 1'b0);
    repeat (2) @(negedge tx_clk);
    check("rstmid_pre_count", 32'(fifo_count), 32'(PRE_RST_COUNT));
    check("rstmid_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge tx_clk);
    reset = 1'b0;
    check("rstmid_count", 32'(fifo_count), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_transmit", 32'(bus.transmit), 32'd0);
    check("rstmid_s_ready", 32'(bus.s_ready), 32'd1);
    check("rstmid_tx_data", 32'(bus.tx_data), 32'h0);
    bus.tx_done = 1'b1;
    @(negedge tx_clk);
    bus.tx_done = 1'b0;
    tx_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge tx_clk);
      if (bus.transmit || busy) tx_seen++;
    end
    check("rstmid_late_done_ignored", 32'(tx_seen), 32'd0);
    run_vec(vecs[5], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
